// File: rtl/imx415_cfg_pkg.sv
// Shared types and constants for the IMX415 power-up register sequencer.
// Table entries are {reg_addr, data}; a reg_addr of DELAY_MARK means "wait data ms".
package imx415_cfg_pkg;

  localparam int unsigned REG_AW  = 16;
  localparam int unsigned REG_DW  = 8;
  localparam int unsigned IDX_W   = 8;
  localparam int unsigned ENTRY_W = REG_AW + REG_DW;
  localparam int unsigned WR_W    = 32;

  localparam logic [REG_AW-1:0] DELAY_MARK    = 16'hFFFF;
  localparam logic [7:0]        DEV_ADDR_DFLT = 8'h34;

  typedef struct packed {
    logic [REG_AW-1:0] reg_addr;
    logic [REG_DW-1:0] data;
  } rom_entry_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PWRUP,
    ST_FETCH,
    ST_LOAD,
    ST_DELAY,
    ST_REQ,
    ST_BUSY,
    ST_RETRY,
    ST_NEXT,
    ST_DONE,
    ST_FAIL
  } state_t;

  // I2C write payload, byte0 goes out first: {data, reg_lo, reg_hi, dev_addr}
  function automatic logic [WR_W-1:0] pack_write(input logic [7:0] dev, input rom_entry_t e);
    return {e.data, e.reg_addr[7:0], e.reg_addr[15:8], dev};
  endfunction

endpackage

// File: rtl/imx415_reg_rom.sv
// Constant IMX415 init table, one registered read per cycle.
// Unlisted indices read as a zero-length delay, i.e. a one-cycle no-op.
module imx415_reg_rom
  import imx415_cfg_pkg::*;
(
  input  logic               I_clk,
  input  logic [IDX_W-1:0]   I_index,
  output logic [ENTRY_W-1:0] O_entry
);

  logic [ENTRY_W-1:0] w_entry;
  logic [ENTRY_W-1:0] r_entry;

  always_comb begin
    w_entry = {DELAY_MARK, 8'h00};
    case (I_index)
      8'd0:  w_entry = {16'h3000, 8'h01};  // standby
      8'd1:  w_entry = {DELAY_MARK, 8'h02};
      8'd2:  w_entry = {16'h3002, 8'h00};
      8'd3:  w_entry = {16'h3008, 8'h54};
      8'd4:  w_entry = {16'h300A, 8'h3B};
      8'd5:  w_entry = {16'h3024, 8'hCA};
      8'd6:  w_entry = {16'h3025, 8'h08};
      8'd7:  w_entry = {16'h3028, 8'h4C};
      8'd8:  w_entry = {16'h3029, 8'h04};
      8'd9:  w_entry = {16'h3031, 8'h00};
      8'd10: w_entry = {16'h3032, 8'h00};
      8'd11: w_entry = {16'h3033, 8'h05};
      8'd12: w_entry = {16'h3050, 8'h08};
      8'd13: w_entry = {16'h30C1, 8'h00};
      8'd14: w_entry = {16'h3116, 8'h24};
      8'd15: w_entry = {16'h3118, 8'hA0};
      8'd16: w_entry = {16'h311E, 8'h24};
      8'd17: w_entry = {16'h32D4, 8'h21};
      8'd18: w_entry = {16'h32EC, 8'hA1};
      8'd19: w_entry = {16'h3452, 8'h7F};
      8'd20: w_entry = {16'h3453, 8'h03};
      8'd21: w_entry = {16'h358A, 8'h04};
      8'd22: w_entry = {16'h35A1, 8'h02};
      8'd23: w_entry = {16'h36BC, 8'h0C};
      8'd24: w_entry = {16'h36CC, 8'h53};
      8'd25: w_entry = {16'h36CD, 8'h00};
      8'd26: w_entry = {16'h36CE, 8'h3C};
      8'd27: w_entry = {16'h36D0, 8'h8C};
      8'd28: w_entry = {16'h36D1, 8'h00};
      8'd29: w_entry = {16'h36D2, 8'h71};
      8'd30: w_entry = {16'h36D4, 8'h3C};
      8'd31: w_entry = {16'h36D6, 8'h53};
      8'd32: w_entry = {16'h36D7, 8'h00};
      8'd33: w_entry = {16'h36D8, 8'h71};
      8'd34: w_entry = {16'h36DA, 8'h8C};
      8'd35: w_entry = {16'h36DB, 8'h00};
      8'd36: w_entry = {16'h3701, 8'h03};
      8'd37: w_entry = {16'h3724, 8'h02};
      8'd38: w_entry = {16'h3726, 8'h02};
      8'd39: w_entry = {16'h3732, 8'h02};
      8'd40: w_entry = {16'h3734, 8'h03};
      8'd41: w_entry = {16'h3736, 8'h03};
      8'd42: w_entry = {16'h3742, 8'h03};
      8'd43: w_entry = {16'h3862, 8'hE0};
      8'd44: w_entry = {16'h38CC, 8'h30};
      8'd45: w_entry = {16'h38CD, 8'h2F};
      8'd46: w_entry = {16'h395C, 8'h0C};
      8'd47: w_entry = {16'h3A42, 8'hD1};
      8'd48: w_entry = {16'h3A4C, 8'h77};
      8'd49: w_entry = {16'h3AE0, 8'h02};
      8'd50: w_entry = {16'h3AEC, 8'h0C};
      8'd51: w_entry = {16'h3B00, 8'h2E};
      8'd52: w_entry = {16'h3B06, 8'h29};
      8'd53: w_entry = {16'h3B98, 8'h25};
      8'd54: w_entry = {16'h3B99, 8'h21};
      8'd55: w_entry = {16'h3B9B, 8'h13};
      8'd56: w_entry = {16'h3B9C, 8'h13};
      8'd57: w_entry = {16'h3B9D, 8'h13};
      8'd58: w_entry = {16'h3B9E, 8'h13};
      8'd59: w_entry = {16'h3BA1, 8'h00};
      8'd60: w_entry = {16'h3BA6, 8'h00};
      8'd61: w_entry = {16'h3000, 8'h00};  // release standby, then let the sensor settle
      8'd62: w_entry = {DELAY_MARK, 8'h1E};
      8'd63: w_entry = {16'h3002, 8'h00};
      default: w_entry = {DELAY_MARK, 8'h00};
    endcase
  end

  always_ff @(posedge I_clk) begin
    r_entry <= w_entry;
  end

  assign O_entry = r_entry;

endmodule

// File: rtl/imx415_reg_seq.sv
// IMX415 power-up register sequencer: walks the init table and issues one
// 4-byte I2C write per entry, with table delays and per-write retry.
module imx415_reg_seq
  import imx415_cfg_pkg::*;
#(
  parameter logic [7:0]  DEV_ADDR    = DEV_ADDR_DFLT,
  parameter logic [7:0]  REG_NUM     = 8'd64,
  parameter logic [16:0] MS_CYCLES   = 17'd25000,
  parameter logic [15:0] PWRUP_MS    = 16'd20,
  parameter logic [1:0]  MAX_RETRY   = 2'd3,
  parameter logic [23:0] TIMEOUT_CYC = 24'd2000000
)(
  input  logic        I_clk,
  input  logic        I_rst,
  input  logic        I_cfg_start,
  output logic        O_iic_req,
  output logic        O_iic_mode,
  output logic [31:0] O_wr_data,
  output logic [7:0]  O_wr_cnt,
  output logic [7:0]  O_rd_cnt,
  input  logic        I_iic_busy,
  input  logic        I_iic_bus_error,
  output logic        O_cfg_busy,
  output logic        O_cfg_done,
  output logic        O_cfg_error,
  output logic [7:0]  O_cfg_index
);

  state_t             r_state, w_state_nxt;
  logic [1:0]         r_busy_sync, r_err_sync;
  logic               w_busy_s, w_err_s;
  logic [16:0]        r_ms_cnt, w_ms_cnt_nxt;
  logic [15:0]        r_ms_elapsed, w_ms_elapsed_nxt;
  logic               w_ms_tick, w_ms_restart;
  logic [7:0]         r_delay_ms, w_delay_ms_nxt;
  logic [1:0]         r_retry, w_retry_nxt;
  logic [23:0]        r_tmo, w_tmo_nxt;
  logic               w_tmo_hit;
  logic               r_err_seen, w_err_seen_nxt;
  logic [IDX_W-1:0]   r_index, w_index_nxt;
  logic [WR_W-1:0]    r_wr_data, w_wr_data_nxt;
  logic               r_req, r_cfg_busy;
  logic               r_cfg_done, w_cfg_done_nxt;
  logic               r_cfg_error, w_cfg_error_nxt;
  logic [ENTRY_W-1:0] w_rom_q;
  rom_entry_t         w_entry;

  imx415_reg_rom u_rom (
    .I_clk   (I_clk),
    .I_index (r_index),
    .O_entry (w_rom_q)
  );

  assign w_entry   = rom_entry_t'(w_rom_q);
  assign w_busy_s  = r_busy_sync[1];
  assign w_err_s   = r_err_sync[1];
  assign w_ms_tick = (r_ms_cnt == MS_CYCLES - 17'd1);
  assign w_tmo_hit = (r_tmo == TIMEOUT_CYC - 24'd1);

  // Master status comes from a slower logic domain; resynchronise before use.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      r_busy_sync <= 2'b00;
      r_err_sync  <= 2'b00;
    end else begin
      r_busy_sync <= {r_busy_sync[0], I_iic_busy};
      r_err_sync  <= {r_err_sync[0], I_iic_bus_error};
    end
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      r_state      <= ST_IDLE;
      r_ms_cnt     <= '0;
      r_ms_elapsed <= '0;
      r_delay_ms   <= '0;
      r_retry      <= '0;
      r_tmo        <= '0;
      r_err_seen   <= 1'b0;
      r_index      <= '0;
      r_wr_data    <= '0;
      r_req        <= 1'b0;
      r_cfg_busy   <= 1'b0;
      r_cfg_done   <= 1'b0;
      r_cfg_error  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_ms_cnt     <= w_ms_cnt_nxt;
      r_ms_elapsed <= w_ms_elapsed_nxt;
      r_delay_ms   <= w_delay_ms_nxt;
      r_retry      <= w_retry_nxt;
      r_tmo        <= w_tmo_nxt;
      r_err_seen   <= w_err_seen_nxt;
      r_index      <= w_index_nxt;
      r_wr_data    <= w_wr_data_nxt;
      r_req        <= (w_state_nxt == ST_REQ);
      r_cfg_busy   <= !(w_state_nxt inside {ST_IDLE, ST_DONE, ST_FAIL});
      r_cfg_done   <= w_cfg_done_nxt;
      r_cfg_error  <= w_cfg_error_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_ms_restart     = 1'b0;
    w_ms_cnt_nxt     = w_ms_tick ? 17'd0 : r_ms_cnt + 17'd1;
    w_ms_elapsed_nxt = r_ms_elapsed;
    w_delay_ms_nxt   = r_delay_ms;
    w_retry_nxt      = r_retry;
    w_tmo_nxt        = r_tmo;
    w_err_seen_nxt   = r_err_seen;
    w_index_nxt      = r_index;
    w_wr_data_nxt    = r_wr_data;
    w_cfg_done_nxt   = r_cfg_done;
    w_cfg_error_nxt  = r_cfg_error;

    case (r_state)
      ST_IDLE, ST_DONE, ST_FAIL: begin
        if (I_cfg_start) begin
          w_state_nxt     = ST_PWRUP;
          w_cfg_done_nxt  = 1'b0;
          w_cfg_error_nxt = 1'b0;
          w_index_nxt     = '0;
          w_retry_nxt     = '0;
          w_ms_restart    = 1'b1;
        end
      end
      ST_PWRUP: begin
        if (r_ms_elapsed >= PWRUP_MS) begin
          w_state_nxt = ST_FETCH;
        end else if (w_ms_tick) begin
          w_ms_elapsed_nxt = r_ms_elapsed + 16'd1;
        end
      end
      ST_FETCH: w_state_nxt = ST_LOAD;
      // ROM data for r_index is valid one cycle after FETCH
      ST_LOAD: begin
        if (w_entry.reg_addr == DELAY_MARK) begin
          w_delay_ms_nxt = w_entry.data;
          w_state_nxt    = ST_DELAY;
          w_ms_restart   = 1'b1;
        end else begin
          w_wr_data_nxt  = pack_write(DEV_ADDR, w_entry);
          w_tmo_nxt      = '0;
          w_err_seen_nxt = 1'b0;
          w_state_nxt    = ST_REQ;
        end
      end
      ST_DELAY: begin
        if (r_ms_elapsed >= {8'd0, r_delay_ms}) begin
          w_state_nxt = ST_NEXT;
        end else if (w_ms_tick) begin
          w_ms_elapsed_nxt = r_ms_elapsed + 16'd1;
        end
      end
      ST_REQ: begin
        w_tmo_nxt = r_tmo + 24'd1;
        if (w_tmo_hit) begin
          w_state_nxt  = ST_RETRY;
          w_ms_restart = 1'b1;
        end else if (w_busy_s) begin
          w_state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        w_tmo_nxt      = r_tmo + 24'd1;
        w_err_seen_nxt = r_err_seen | w_err_s;
        if (w_tmo_hit) begin
          w_state_nxt  = ST_RETRY;
          w_ms_restart = 1'b1;
        end else if (!w_busy_s) begin
          if (r_err_seen | w_err_s) begin
            w_state_nxt  = ST_RETRY;
            w_ms_restart = 1'b1;
          end else begin
            w_state_nxt = ST_NEXT;
          end
        end
      end
      ST_RETRY: begin
        if (r_retry == MAX_RETRY) begin
          w_cfg_error_nxt = 1'b1;
          w_state_nxt     = ST_FAIL;
        end else if (w_ms_tick) begin
          w_retry_nxt    = r_retry + 2'd1;
          w_tmo_nxt      = '0;
          w_err_seen_nxt = 1'b0;
          w_state_nxt    = ST_REQ;
        end
      end
      ST_NEXT: begin
        w_retry_nxt = '0;
        if (r_index == REG_NUM - 8'd1) begin
          w_cfg_done_nxt = 1'b1;
          w_state_nxt    = ST_DONE;
        end else begin
          w_index_nxt = r_index + 8'd1;
          w_state_nxt = ST_FETCH;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    if (w_ms_restart) begin
      w_ms_cnt_nxt     = '0;
      w_ms_elapsed_nxt = '0;
    end
  end

  assign O_iic_req   = r_req;
  assign O_iic_mode  = 1'b0;
  assign O_wr_data   = r_wr_data;
  assign O_wr_cnt    = 8'd4;
  assign O_rd_cnt    = 8'd0;
  assign O_cfg_busy  = r_cfg_busy;
  assign O_cfg_done  = r_cfg_done;
  assign O_cfg_error = r_cfg_error;
  assign O_cfg_index = r_index;

endmodule

// File: tb/tb_imx415_reg_seq.sv
// Bench for imx415_reg_seq: I2C master BFM with NACK injection and a write-data scoreboard.
module tb_imx415_reg_seq;

  logic        I_clk = 1'b0;
  logic        I_rst = 1'b1;
  logic        I_cfg_start = 1'b0;
  logic        I_iic_busy = 1'b0;
  logic        I_iic_bus_error = 1'b0;
  logic        O_iic_req, O_iic_mode, O_cfg_busy, O_cfg_done, O_cfg_error;
  logic [31:0] O_wr_data;
  logic [7:0]  O_wr_cnt, O_rd_cnt, O_cfg_index;

  imx415_reg_seq #(
    .DEV_ADDR    (8'h34),
    .REG_NUM     (8'd3),
    .MS_CYCLES   (17'd10),
    .PWRUP_MS    (16'd2),
    .MAX_RETRY   (2'd3),
    .TIMEOUT_CYC (24'd100)
  ) dut (
    .I_clk           (I_clk),
    .I_rst           (I_rst),
    .I_cfg_start     (I_cfg_start),
    .O_iic_req       (O_iic_req),
    .O_iic_mode      (O_iic_mode),
    .O_wr_data       (O_wr_data),
    .O_wr_cnt        (O_wr_cnt),
    .O_rd_cnt        (O_rd_cnt),
    .I_iic_busy      (I_iic_busy),
    .I_iic_bus_error (I_iic_bus_error),
    .O_cfg_busy      (O_cfg_busy),
    .O_cfg_done      (O_cfg_done),
    .O_cfg_error     (O_cfg_error),
    .O_cfg_index     (O_cfg_index)
  );

  always #5 I_clk = ~I_clk;

  localparam logic [31:0] WR0 = 32'h0100_3034;
  localparam logic [31:0] WR2 = 32'h0002_3034;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge I_clk) cyc <= cyc + 1;

  logic [31:0] sb_q[$];
  int          rise_cyc[$];
  int          fall_cyc[$];
  int          pulses = 0;
  int          req_width_last = 0;
  int          st_cyc = 0;

  bit bfm_busy_en  = 1'b1;
  bit bfm_nack_all = 1'b0;
  int bfm_nack_at  = -1;
  int bfm_n        = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Monitor: every rising req is one write attempt; compare against the scoreboard
  logic req_d = 1'b0;
  int   width = 0;
  always @(negedge I_clk) begin
    if (O_iic_req && !req_d) begin
      pulses++;
      rise_cyc.push_back(cyc);
      if (sb_q.size() == 0) chk("sb_unexpected_wr", O_wr_data, 32'hFFFF_FFFF);
      else chk("sb_wr_data", O_wr_data, sb_q.pop_front());
      width = 1;
    end else if (O_iic_req) begin
      width++;
    end
    if (!O_iic_req && req_d) req_width_last = width;
    req_d = O_iic_req;
  end

  // I2C master BFM: busy rises 3 cycles after req, error pulses mid-transfer on NACK
  initial begin
    forever begin
      bit nack;
      @(negedge I_clk);
      if (O_iic_req && bfm_busy_en) begin
        nack = bfm_nack_all || (bfm_n == bfm_nack_at);
        bfm_n++;
        repeat (3) @(negedge I_clk);
        I_iic_busy = 1'b1;
        repeat (4) @(negedge I_clk);
        I_iic_bus_error = nack;
        repeat (4) @(negedge I_clk);
        I_iic_bus_error = 1'b0;
        repeat (4) @(negedge I_clk);
        I_iic_busy = 1'b0;
        fall_cyc.push_back(cyc);
      end
    end
  end

  task automatic pulse_start();
    @(negedge I_clk);
    I_cfg_start = 1'b1;
    st_cyc = cyc;
    @(negedge I_clk);
    I_cfg_start = 1'b0;
  endtask

  task automatic wait_end(input string tag, input int budget);
    int n = 0;
    while (!(O_cfg_done || O_cfg_error) && n < budget) begin
      @(negedge I_clk);
      n++;
    end
    chk(tag, 32'(O_cfg_done || O_cfg_error), 32'd1);
  endtask

  task automatic wait_req(input logic lvl, input string tag);
    int n = 0;
    while (O_iic_req !== lvl && n < 500) begin
      @(negedge I_clk);
      n++;
    end
    chk(tag, 32'(O_iic_req), 32'(lvl));
  endtask

  task automatic new_test(input int nack_at, input bit nack_all, input bit busy_en);
    bfm_nack_at  = nack_at;
    bfm_nack_all = nack_all;
    bfm_busy_en  = busy_en;
    bfm_n        = 0;
    pulses       = 0;
    rise_cyc.delete();
    fall_cyc.delete();
  endtask

  int lat1;

  initial begin
    // Reset state
    repeat (3) @(negedge I_clk);
    chk("rst_req",     32'(O_iic_req),   32'd0);
    chk("rst_busy",    32'(O_cfg_busy),  32'd0);
    chk("rst_done",    32'(O_cfg_done),  32'd0);
    chk("rst_error",   32'(O_cfg_error), 32'd0);
    chk("rst_index",   32'(O_cfg_index), 32'd0);
    chk("rst_wr_data", O_wr_data,        32'd0);
    chk("const_mode",  32'(O_iic_mode),  32'd0);
    chk("const_wrcnt", 32'(O_wr_cnt),    32'd4);
    chk("const_rdcnt", 32'(O_rd_cnt),    32'd0);
    I_rst = 1'b0;
    repeat (2) @(negedge I_clk);

    // 1: plain 3-entry walk with an embedded 2 ms delay
    new_test(-1, 1'b0, 1'b1);
    sb_q.push_back(WR0);
    sb_q.push_back(WR2);
    pulse_start();
    chk("t1_busy_on", 32'(O_cfg_busy), 32'd1);
    wait_end("t1_end", 3000);
    @(negedge I_clk);
    chk("t1_done",   32'(O_cfg_done),  32'd1);
    chk("t1_error",  32'(O_cfg_error), 32'd0);
    chk("t1_busy",   32'(O_cfg_busy),  32'd0);
    chk("t1_index",  32'(O_cfg_index), 32'd2);
    chk("t1_pulses", 32'(pulses),      32'd2);
    chk("t1_sb_left", 32'(sb_q.size()), 32'd0);
    lat1 = (rise_cyc.size() > 0) ? rise_cyc[0] - st_cyc : -1;
    if (rise_cyc.size() >= 2 && fall_cyc.size() >= 1)
      chk("t1_gap_ge20", 32'((rise_cyc[1] - fall_cyc[0]) >= 20), 32'd1);
    else
      chk("t1_gap_data", 32'(rise_cyc.size()), 32'd2);

    // 2: NACK on the first attempt of the second write
    new_test(1, 1'b0, 1'b1);
    sb_q.push_back(WR0);
    sb_q.push_back(WR2);
    sb_q.push_back(WR2);
    pulse_start();
    wait_end("t2_end", 3000);
    @(negedge I_clk);
    chk("t2_done",   32'(O_cfg_done),  32'd1);
    chk("t2_error",  32'(O_cfg_error), 32'd0);
    chk("t2_pulses", 32'(pulses),      32'd3);
    chk("t2_sb_left", 32'(sb_q.size()), 32'd0);

    // 3: NACK on every attempt of entry 0
    new_test(-1, 1'b1, 1'b1);
    repeat (4) sb_q.push_back(WR0);
    pulse_start();
    wait_end("t3_end", 3000);
    @(negedge I_clk);
    chk("t3_error",  32'(O_cfg_error), 32'd1);
    chk("t3_done",   32'(O_cfg_done),  32'd0);
    chk("t3_index",  32'(O_cfg_index), 32'd0);
    chk("t3_busy",   32'(O_cfg_busy),  32'd0);
    chk("t3_pulses", 32'(pulses),      32'd4);
    chk("t3_sb_left", 32'(sb_q.size()), 32'd0);

    // 4: master never goes busy; each attempt must time out after 100 cycles
    new_test(-1, 1'b0, 1'b0);
    repeat (4) sb_q.push_back(WR0);
    pulse_start();
    wait_end("t4_end", 3000);
    @(negedge I_clk);
    chk("t4_error",     32'(O_cfg_error),    32'd1);
    chk("t4_done",      32'(O_cfg_done),     32'd0);
    chk("t4_req_width", 32'(req_width_last), 32'd100);
    chk("t4_pulses",    32'(pulses),         32'd4);
    chk("t4_sb_left",   32'(sb_q.size()),    32'd0);

    // 5: reset while the master is busy
    new_test(-1, 1'b0, 1'b1);
    sb_q.push_back(WR0);
    pulse_start();
    wait_req(1'b1, "t5_req_rise");
    wait_req(1'b0, "t5_req_fall");
    repeat (2) @(negedge I_clk);
    I_rst = 1'b1;
    @(negedge I_clk);
    chk("t5_req",     32'(O_iic_req),   32'd0);
    chk("t5_busy",    32'(O_cfg_busy),  32'd0);
    chk("t5_done",    32'(O_cfg_done),  32'd0);
    chk("t5_error",   32'(O_cfg_error), 32'd0);
    chk("t5_index",   32'(O_cfg_index), 32'd0);
    chk("t5_wr_data", O_wr_data,        32'd0);
    I_rst = 1'b0;
    repeat (200) @(negedge I_clk);
    chk("t5_no_req",  32'(pulses),       32'd1);
    chk("t5_sb_left", 32'(sb_q.size()),  32'd0);

    // 6: start during power-up is ignored; start after done replays the table
    new_test(-1, 1'b0, 1'b1);
    sb_q.push_back(WR0);
    sb_q.push_back(WR2);
    pulse_start();
    repeat (8) @(negedge I_clk);
    I_cfg_start = 1'b1;
    @(negedge I_clk);
    I_cfg_start = 1'b0;
    chk("t6_busy_pwrup", 32'(O_cfg_busy), 32'd1);
    wait_end("t6_end_a", 3000);
    @(negedge I_clk);
    chk("t6_done_a", 32'(O_cfg_done), 32'd1);
    chk("t6_lat_a",  32'((rise_cyc.size() > 0) ? rise_cyc[0] - st_cyc : -1), 32'(lat1));
    new_test(-1, 1'b0, 1'b1);
    sb_q.push_back(WR0);
    sb_q.push_back(WR2);
    pulse_start();
    chk("t6_done_clr", 32'(O_cfg_done), 32'd0);
    chk("t6_busy_b",   32'(O_cfg_busy), 32'd1);
    wait_end("t6_end_b", 3000);
    @(negedge I_clk);
    chk("t6_done_b",   32'(O_cfg_done),   32'd1);
    chk("t6_pulses_b", 32'(pulses),       32'd2);
    chk("t6_lat_b",    32'((rise_cyc.size() > 0) ? rise_cyc[0] - st_cyc : -1), 32'(lat1));
    chk("t6_sb_left",  32'(sb_q.size()),  32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
